dsm_dac_core: RTL and testbench
===============================

Name: dsm_dac_core

Overview:
- Parametrised successor to the team's first-order delta-sigma DAC. Modulator order is selectable (1 or 2), input width is configurable, and integrators saturate instead of wrapping.
- Accepts signed PCM samples over a valid/ready handshake into a one-entry holding buffer. Each sample is held for OSR modulator ticks.
- Produces a 1-bit density output for an external RC filter/pin. Sits between the audio/sample source and the output pad.

Parameters:
- WIDTH, 16, signed two's-complement input sample width.
- ORDER, 2, modulator order; legal values 1 or 2; any other value is a synthesis error.
- OSR, 64, clk_en ticks per sample; must be at least 2.
- ACC_EXT, 4, integrator guard bits; ACC_W = WIDTH+ACC_EXT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- clk_en  in  1  modulator tick enable; every state update is gated by it except the handshake.
- s_valid  in  1  sample valid.
- s_data  in  WIDTH  signed sample.
- s_ready  out  1  buffer can accept a sample.
- dsm_out  out  1  modulator bitstream.
- underrun  out  1  sticky flag: a sample boundary passed with the buffer empty.
- running  out  1  high in RUN state.

Behaviour:
- Reset (rst=0 at clk edge): buffer empty, s_ready=1, dsm_out=0, underrun=0, running=0, integrators=0, tick counter=0, state IDLE.
- Handshake: a sample is accepted when s_valid&&s_ready.
  - s_ready = ~buf_full | load.
  - When load and accept occur in the same cycle, the buffer stays full with the new sample.
- Tick counter: 0..OSR-1, increments on clk_en in RUN and wraps to 0.
  - load = clk_en && ((state==RUN && cnt==OSR-1) || (state==IDLE && buf_full)).
- On load:
  - If buf_full: cur_x <= buffer, buffer empties unless refilled.
  - If RUN and buffer empty: cur_x keeps its old value, underrun <= 1 (sticky until reset).
- FSM:
  - IDLE: integrators held at 0, dsm_out=0.
  - IDLE -> RUN on the first load; cnt <= 0.
  - RUN is left only by reset.
- Modulator update, on clk_en in RUN; sample used is cur_x after any load this cycle; all arithmetic signed ACC_W.
  - x = sign-extended sample.
  - fb = dsm_out ? +2^(WIDTH-1) : -2^(WIDTH-1), using dsm_out from before the update.
  - ORDER=1: i1' = sat(i1 + x - fb); dsm_out <= ~i1'[ACC_W-1].
  - ORDER=2: i1' = sat(i1 + x - fb); i2' = sat(i2 + i1' - fb); dsm_out <= ~i2'[ACC_W-1].
  - Output is registered from the new integrator value in the same tick; latency from load to first affected bit is 1 clk_en tick.
- sat(): clamp to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; never wrap.
- Full-scale inputs:
  - s_data=+max gives ones density (2^(W-1)-1)/2^W + 1/2.
  - -2^(W-1) gives all-zeros in steady state.
- clk_en=0: state, counter, integrators and dsm_out hold; handshake still operates.
- Reset mid-operation: everything returns to reset values on the next edge; any buffered sample is discarded.

Optional Feature:
- Macro DSM_DAC_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 at reset, advances on every clk_en in RUN.
  - Its two LSBs, taken as a signed value in -2..+1, are added to the last integrator input before saturation.
  - Suppresses idle tones.
- Undefined: no LFSR logic; behaviour exactly as above.

Decomposition:
- Package dsm_dac_pkg holds:
  - typedef enum logic {IDLE, RUN} dsm_state_e;
  - function sat_acc (parametrised by width via a localparam in caller);
  - LFSR seed and taps constants.
- One sub-module, dsm_sample_buf: the one-entry valid/ready holding buffer with load/consume port.
- Modulator datapath and FSM stay in dsm_dac_core.

Test Plan:
- Reset check: rst=0 for 3 cycles, s_valid=0 -> dsm_out=0, s_ready=1, running=0, underrun=0. Hold clk_en=1 with no sample -> stays in IDLE.
- ORDER=1, WIDTH=16, OSR=4: feed sample 0 continuously -> dsm_out alternates 1,0,1,0 after start; ones count over 256 ticks is exactly 128.
- ORDER=2, constant 16'h4000 -> ones density over 4096 ticks within 0.75±0.002. Neither integrator ever reaches a saturation bound.
- Sample 16'h8000 then 16'h7FFF for 1000 ticks each:
  - Integrators clamp at their bounds and never wrap; no sign flip of an integrator after a clamp.
  - Density recovers to ≥0.99 within 20 ticks.
- Underrun: OSR=8, supply one sample then stop -> underrun rises on the clk_en that completes the 8th tick. It stays 1, and the output keeps modulating the last sample.
- Handshake:
  - Assert s_valid while the buffer is full and no load occurs -> s_ready=0, no overwrite.
  - On a load cycle -> s_ready=1, accept and load both occur, and the next sample is buffered.
  - With clk_en=0 throughout, a sample is accepted into an empty buffer and the state stays IDLE.

Source files
------------

// File: rtl/dsm_dac_pkg.sv
// dsm_dac_pkg: shared state type, saturation helper and dither LFSR constants
package dsm_dac_pkg;
    typedef enum logic {IDLE, RUN} dsm_state_e;
    localparam int SAT_W = 64;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/dsm_dac_if.sv
// dsm_dac_if: valid/ready PCM sample stream into the DAC
interface dsm_dac_if #(parameter int WIDTH = 16);
    logic s_valid;
    logic signed [WIDTH-1:0] s_data;
    logic s_ready;
    modport master (output s_valid, output s_data, input s_ready);
    modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dsm_sample_buf.sv
// dsm_sample_buf: one-entry holding buffer, refillable in the same cycle it is consumed
module dsm_sample_buf #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dsm_dac_if.slave                s,
    input  logic                    load,
    output logic                    full,
    output logic signed [WIDTH-1:0] data
);
    logic ready;
    logic accept;
    assign ready = ~full | load;
    assign accept = s.s_valid & ready;
    assign s.s_ready = ready;
    // an accept always leaves the entry full; a load without accept drains it
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (accept) begin
            full <= 1'b1;
            data <= s.s_data;
        end else if (load) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/dsm_dac_core.sv
// dsm_dac_core: order-1/2 delta-sigma DAC with saturating integrators; DSM_DAC_DITHER_EN adds LFSR dither
module dsm_dac_core
    import dsm_dac_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ORDER   = 2,
    parameter int OSR     = 64,
    parameter int ACC_EXT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clk_en,
    dsm_dac_if.slave s,
    output logic     dsm_out,
    output logic     underrun,
    output logic     running
);
    localparam int ACC_W = WIDTH + ACC_EXT;
    localparam int SUM_W = ACC_W + 2;
    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSR - 1);
    localparam logic signed [SUM_W-1:0] FB = SUM_W'(1) <<< (WIDTH - 1);

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("dsm_dac_core: ORDER must be 1 or 2");
    end
    if (OSR < 2) begin : g_bad_osr
        $error("dsm_dac_core: OSR must be at least 2");
    end

    dsm_state_e state, state_n;
    logic [CNT_W-1:0] cnt;
    logic buf_full, load, out_n;
    logic signed [WIDTH-1:0] buf_data, cur_x, x_now;
    logic signed [ACC_W-1:0] i1, i2, i1_n, i2_n;
    logic signed [SUM_W-1:0] s1, s2, fb, dith;

    dsm_sample_buf #(.WIDTH(WIDTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .load (load),
        .full (buf_full),
        .data (buf_data)
    );

    assign load = clk_en && ((state == RUN && cnt == CNT_MAX) || (state == IDLE && buf_full));
    assign x_now = (load && buf_full) ? buf_data : cur_x;
    assign fb = dsm_out ? FB : -FB;
    assign running = state == RUN;

`ifdef DSM_DAC_DITHER_EN
    logic [15:0] lfsr;
    // dither LFSR steps once per modulator tick
    always_ff @(posedge clk) begin
        if (!rst) lfsr <= LFSR_SEED;
        else if (clk_en && state == RUN) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
    assign dith = SUM_W'(signed'(lfsr[1:0]));
`else
    assign dith = '0;
`endif

    // next state: leave IDLE on the first load, RUN is only left through reset
    always_comb begin
        state_n = state;
        if (state == IDLE && load) state_n = RUN;
    end

    // one modulator tick; dither enters the last integrator, every sum is clamped
    always_comb begin
        s1 = SUM_W'(i1) + SUM_W'(x_now) - fb + (ORDER == 1 ? dith : SUM_W'(0));
        i1_n = ACC_W'(sat_acc(SAT_W'(s1), ACC_W));
        s2 = SUM_W'(i2) + SUM_W'(i1_n) - fb + (ORDER == 2 ? dith : SUM_W'(0));
        i2_n = ACC_W'(sat_acc(SAT_W'(s2), ACC_W));
        out_n = ORDER == 1 ? ~i1_n[ACC_W-1] : ~i2_n[ACC_W-1];
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    // sample latch, underrun flag, tick counter and integrators
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            cur_x    <= '0;
            i1       <= '0;
            i2       <= '0;
            dsm_out  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (load && buf_full) cur_x <= buf_data;
            underrun <= underrun | (load & ~buf_full);
            if (clk_en && state == RUN) begin
                cnt     <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
                i1      <= i1_n;
                i2      <= ORDER == 2 ? i2_n : '0;
                dsm_out <= out_n;
            end
        end
    end
endmodule

// File: tb/tb_dsm_dac_core.sv
// tb_dsm_dac_core: checks an order-1 and an order-2 DAC against a queue-based reference model
module tb_dsm_dac_core;
    localparam int W = 16;
    localparam longint H = 32768;
    localparam longint AMAX = 524287;
    localparam longint AMIN = -524288;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    logic s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic out0, und0, run0, out1, und1, run1;
    int n_chk = 0;
    int n_pass = 0;

    dsm_dac_if #(.WIDTH(W)) if0 ();
    dsm_dac_if #(.WIDTH(W)) if1 ();
    assign if0.s_valid = s_valid;
    assign if0.s_data = s_data;
    assign if1.s_valid = s_valid;
    assign if1.s_data = s_data;

    dsm_dac_core #(.WIDTH(W), .ORDER(1), .OSR(4), .ACC_EXT(4)) u_o1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .s(if0),
        .dsm_out(out0), .underrun(und0), .running(run0)
    );
    dsm_dac_core #(.WIDTH(W), .ORDER(2), .OSR(8), .ACC_EXT(4)) u_o2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .s(if1),
        .dsm_out(out1), .underrun(und1), .running(run1)
    );

    always #5 clk = ~clk;

    // reference model: index 0 = ORDER 1 / OSR 4, index 1 = ORDER 2 / OSR 8
    bit m_run[2], m_out[2], m_und[2];
    longint m_n[2], m_x[2], m_i1[2], m_i2[2];
    longint q0[$], q1[$];

    function automatic longint clamp(longint v);
        return v > AMAX ? AMAX : (v < AMIN ? AMIN : v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_out[d] = 0; m_und[d] = 0;
            m_n[d] = 0; m_x[d] = 0; m_i1[d] = 0; m_i2[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step(input int d, input bit en, input bit acc, input longint xin);
        int osr;
        longint fb;
        bit have;
        osr = d == 0 ? 4 : 8;
        have = d == 0 ? q0.size() > 0 : q1.size() > 0;
        if (en) begin
            if (m_run[d]) begin
                if (m_n[d] % osr == osr - 1) begin
                    if (have) m_x[d] = d == 0 ? q0.pop_front() : q1.pop_front();
                    else m_und[d] = 1'b1;
                end
                fb = m_out[d] ? H : -H;
                m_i1[d] = clamp(m_i1[d] + m_x[d] - fb);
                if (d == 1) m_i2[d] = clamp(m_i2[d] + m_i1[d] - fb);
                m_out[d] = (d == 1 ? m_i2[d] : m_i1[d]) >= 0;
                m_n[d]++;
            end else if (have) begin
                m_x[d] = d == 0 ? q0.pop_front() : q1.pop_front();
                m_run[d] = 1'b1;
            end
        end
        if (acc) begin
            if (d == 0) q0.push_back(xin);
            else q1.push_back(xin);
        end
    endtask

    task automatic cyc(input bit en);
        bit a0, a1;
        longint xs;
        clk_en = en;
        #1;
        xs = longint'(signed'(s_data));
        a0 = rst && s_valid && if0.s_ready;
        a1 = rst && s_valid && if1.s_ready;
        if (!rst) model_reset();
        else begin
            model_step(0, en, a0, xs);
            model_step(1, en, a1, xs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        repeat (3) cyc(1);
        n_chk++; if (out1 !== 1'b0) $display("FAIL reset_dsm_out got %b want 0", out1); else n_pass++;
        n_chk++; if (if1.s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", if1.s_ready); else n_pass++;
        n_chk++; if (run1 !== 1'b0) $display("FAIL reset_running got %b want 0", run1); else n_pass++;
        n_chk++; if (und1 !== 1'b0) $display("FAIL reset_underrun got %b want 0", und1); else n_pass++;
        n_chk++; if ({out0, run0, und0} !== 3'b000) $display("FAIL reset_o1_outputs got %b want 000", {out0, run0, und0}); else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_chk++; if ({run0, run1, out1} !== 3'b000) $display("FAIL idle_no_sample t=%0d run0/run1/out got %b want 000", i, {run0, run1, out1}); else n_pass++;
        end
    endtask

    task automatic test_order1_zero();
        int ones;
        ones = 0;
        do_reset();
        s_valid = 1'b1;
        s_data = '0;
        for (int i = 0; i < 260; i++) begin
            cyc(1);
            n_chk++; if (out0 !== m_out[0]) $display("FAIL o1_zero_bit t=%0d got %b want %b", i, out0, m_out[0]); else n_pass++;
            if (i >= 4) ones += int'(out0);
        end
        n_chk++; if (ones != 128) $display("FAIL o1_zero_ones got %0d want 128", ones); else n_pass++;
    endtask

    task automatic test_order2_density();
        int ones;
        bit hit;
        ones = 0;
        hit = 0;
        do_reset();
        s_valid = 1'b1;
        s_data = 16'h4000;
        for (int i = 0; i < 64 + 4096; i++) begin
            cyc(1);
            n_chk++; if (out1 !== m_out[1]) $display("FAIL o2_half_bit t=%0d got %b want %b", i, out1, m_out[1]); else n_pass++;
            if (i >= 64) ones += int'(out1);
            if (longint'(u_o2.i1) == AMAX || longint'(u_o2.i1) == AMIN || longint'(u_o2.i2) == AMAX || longint'(u_o2.i2) == AMIN) hit = 1;
        end
        n_chk++; if (ones < 3064 || ones > 3080) $display("FAIL o2_half_density got %0d ones want 3064..3080", ones); else n_pass++;
        n_chk++; if (hit !== 1'b0) $display("FAIL o2_half_no_sat got %b want 0", hit); else n_pass++;
    endtask

    task automatic test_saturation();
        int ones;
        bit hit_lo, hit_hi;
        ones = 0;
        hit_lo = 0;
        hit_hi = 0;
        do_reset();
        s_valid = 1'b1;
        s_data = 16'h8000;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) s_data = 16'h7FFF;
            cyc(1);
            n_chk++; if (out1 !== m_out[1]) $display("FAIL sat_bit t=%0d got %b want %b", i, out1, m_out[1]); else n_pass++;
            n_chk++; if (longint'(u_o2.i1) !== m_i1[1] || longint'(u_o2.i2) !== m_i2[1])
                $display("FAIL sat_integ t=%0d got %0d/%0d want %0d/%0d", i, u_o2.i1, u_o2.i2, m_i1[1], m_i2[1]);
            else n_pass++;
            if (longint'(u_o2.i2) == AMIN) hit_lo = 1;
            if (longint'(u_o2.i2) == AMAX) hit_hi = 1;
            if (i == 900 || i == 1036) ones = 0;
            if ((i >= 900 && i < 1000) || (i >= 1036 && i < 1136)) ones += int'(out1);
            if (i == 999) begin
                n_chk++; if (ones != 0) $display("FAIL sat_neg_zeros got %0d ones want 0", ones); else n_pass++;
            end
            if (i == 1135) begin
                n_chk++; if (ones < 99) $display("FAIL sat_pos_recover got %0d ones want >=99", ones); else n_pass++;
            end
        end
        n_chk++; if ({hit_lo, hit_hi} !== 2'b11) $display("FAIL sat_bounds_hit got %b want 11", {hit_lo, hit_hi}); else n_pass++;
    endtask

    task automatic test_underrun();
        int rise0, rise1;
        rise0 = -1;
        rise1 = -1;
        do_reset();
        s_valid = 1'b1;
        s_data = 16'($urandom_range(0, 65535));
        cyc(1);
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            n_chk++; if ({out0, und0, out1, und1} !== {m_out[0], m_und[0], m_out[1], m_und[1]})
                $display("FAIL underrun_model t=%0d got %b want %b", i, {out0, und0, out1, und1}, {m_out[0], m_und[0], m_out[1], m_und[1]});
            else n_pass++;
            if (und0 && rise0 < 0) rise0 = i;
            if (und1 && rise1 < 0) rise1 = i;
        end
        n_chk++; if (rise1 != 8) $display("FAIL underrun_osr8_rise got %0d want 8", rise1); else n_pass++;
        n_chk++; if (rise0 != 4) $display("FAIL underrun_osr4_rise got %0d want 4", rise0); else n_pass++;
        n_chk++; if (und1 !== 1'b1) $display("FAIL underrun_sticky got %b want 1", und1); else n_pass++;
    endtask

    task automatic test_handshake();
        do_reset();
        clk_en = 1'b0;
        s_valid = 1'b1;
        s_data = 16'($urandom_range(0, 65535));
        #1;
        n_chk++; if (if1.s_ready !== 1'b1) $display("FAIL hs_empty_ready got %b want 1", if1.s_ready); else n_pass++;
        cyc(0);
        s_data = 16'($urandom_range(0, 65535));
        #1;
        n_chk++; if (if1.s_ready !== 1'b0) $display("FAIL hs_full_ready got %b want 0", if1.s_ready); else n_pass++;
        repeat (3) cyc(0);
        n_chk++; if (run1 !== 1'b0) $display("FAIL hs_no_clk_en_idle got %b want 0", run1); else n_pass++;
        clk_en = 1'b1;
        #1;
        n_chk++; if (if1.s_ready !== 1'b1) $display("FAIL hs_idle_load_ready got %b want 1", if1.s_ready); else n_pass++;
        cyc(1);
        s_valid = 1'b0;
        n_chk++; if ({run1, if1.s_ready} !== 2'b10) $display("FAIL hs_after_start run/ready got %b want 10", {run1, if1.s_ready}); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            n_chk++; if (out1 !== m_out[1]) $display("FAIL hs_bit_a t=%0d got %b want %b", i, out1, m_out[1]); else n_pass++;
        end
        s_valid = 1'b1;
        s_data = 16'($urandom_range(0, 65535));
        #1;
        n_chk++; if (if1.s_ready !== 1'b1) $display("FAIL hs_run_load_ready got %b want 1", if1.s_ready); else n_pass++;
        cyc(1);
        s_valid = 1'b0;
        n_chk++; if (if1.s_ready !== 1'b0) $display("FAIL hs_refilled_ready got %b want 0", if1.s_ready); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_chk++; if ({out1, und1} !== {m_out[1], m_und[1]}) $display("FAIL hs_bit_b t=%0d got %b want %b", i, {out1, und1}, {m_out[1], m_und[1]}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_data = 16'($urandom_range(0, 65535));
            cyc(1);
            n_chk++; if (out1 !== m_out[1]) $display("FAIL mid_bit t=%0d got %b want %b", i, out1, m_out[1]); else n_pass++;
        end
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        s_valid = 1'b0;
        n_chk++; if ({if1.s_ready, run1, out1, und1} !== 4'b1000) $display("FAIL mid_reset ready/run/out/und got %b want 1000", {if1.s_ready, run1, out1, und1}); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_chk++; if ({run0, run1} !== 2'b00) $display("FAIL mid_discard t=%0d running got %b want 00", i, {run0, run1}); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_order1_zero();
        test_order2_density();
        test_saturation();
        test_underrun();
        test_handshake();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
